// File: rtl/mem_stage_ctrl_if.sv
// Data-memory request/acknowledge bus between the MEM pipeline stage and
// the data memory.
//
// Signals
//   mem_req    stage -> mem   request, held high until acknowledged
//   mem_we     stage -> mem   1 = write, 0 = read
//   mem_addr   stage -> mem   access address
//   mem_wdata  stage -> mem   store data
//   mem_ack    mem -> stage   one-cycle completion pulse
//   mem_rdata  mem -> stage   load data, valid while mem_ack is high on a read
//
// Modports
//   master  the pipeline stage issuing accesses
//   slave   the memory answering them
interface mem_stage_ctrl_if #(
  parameter int DATA_W = 16
);
  logic              mem_req;
  logic              mem_we;
  logic [DATA_W-1:0] mem_addr;
  logic [DATA_W-1:0] mem_wdata;
  logic              mem_ack;
  logic [DATA_W-1:0] mem_rdata;

  modport master (
    output mem_req, mem_we, mem_addr, mem_wdata,
    input  mem_ack, mem_rdata
  );

  modport slave (
    input  mem_req, mem_we, mem_addr, mem_wdata,
    output mem_ack, mem_rdata
  );
endinterface

// File: rtl/mem_stage_ctrl.sv
// Memory stage of the 5-stage 16-bit pipeline. Sits between the EX/MEM
// register and writeback: runs multi-cycle data-memory accesses over a
// req/ack bus, stalls the front of the pipeline until an access finishes,
// selects the writeback value and holds it in the MEM/WB register.
//
// Ports
//   clk, rst_n          pipeline clock (rising edge), async active-low reset
//   M_*                 EX/MEM register contents (dest, ALU result/address,
//                       store data, PC+2, halt and control bits)
//   memBus (master)     data-memory req/we/addr/wdata out, ack/rdata in
//   stall               combinational: freeze PC, IF/ID, ID/EX, EX/MEM
//   W_*                 MEM/WB register: writeback data, dest, RF write
//                       enable, halt marker
module mem_stage_ctrl #(
  parameter int DATA_W = 16
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [3:0]        M_Destination,
  input  logic [DATA_W-1:0] M_ALUout,
  input  logic [DATA_W-1:0] M_WriteData,
  input  logic [DATA_W-1:0] M_Nxt_Pc,
  input  logic              M_hlt,
  input  logic              M_MemtoReg,
  input  logic              M_MemRead,
  input  logic              M_MemWrite,
  input  logic              M_RegWrite,
  input  logic              M_Pcs,
  mem_stage_ctrl_if.master  memBus,
  output logic              stall,
  output logic [DATA_W-1:0] W_WriteBackData,
  output logic [3:0]        W_Destination,
  output logic              W_RegWrite,
  output logic              W_hlt
);

  typedef enum logic {
    IDLE,
    ACCESS
  } state_t;

  state_t            r_state;
  logic              r_memReq;
  logic              r_memWe;
  logic [DATA_W-1:0] r_memAddr;
  logic [DATA_W-1:0] r_memWdata;

  logic [DATA_W-1:0] r_wbData;
  logic [3:0]        r_wbDest;
  logic              r_wbRegWrite;
  logic              r_wbHlt;

  logic              w_acc;
  logic              w_stall;
  logic [DATA_W-1:0] w_wbSel;

  // A memory op is either a load or a store; when decode sets both, the
  // store wins, so the write-enable is simply MemWrite.
  assign w_acc = M_MemRead | M_MemWrite;

  // Stall on the issue cycle and on every waiting cycle; the ack cycle
  // itself is not stalled, so EX/MEM advances on the edge where MEM/WB
  // captures the finished result.
  always_comb begin
    w_stall = 1'b0;
    if (r_state == IDLE) begin
      w_stall = w_acc;
    end else begin
      w_stall = ~memBus.mem_ack;
    end
  end

  // Writeback select. The load result is taken straight from the bus on the
  // ack cycle, which is the only non-stalled cycle of a load, so MEM/WB is
  // the capture register for mem_rdata.
  always_comb begin
    w_wbSel = M_ALUout;
    if (M_Pcs) begin
      w_wbSel = M_Nxt_Pc;
    end else if (M_MemtoReg) begin
      w_wbSel = memBus.mem_rdata;
    end
  end

  // Access FSM with registered bus outputs. The address/data/direction are
  // latched only when leaving IDLE and stay put for the whole access. The
  // async reset drops mem_req immediately, aborting any access in flight.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state    <= IDLE;
      r_memReq   <= 1'b0;
      r_memWe    <= 1'b0;
      r_memAddr  <= '0;
      r_memWdata <= '0;
    end else begin
      case (r_state)
        IDLE: begin
          if (w_acc) begin
            r_state    <= ACCESS;
            r_memReq   <= 1'b1;
            r_memWe    <= M_MemWrite;
            r_memAddr  <= M_ALUout;
            r_memWdata <= M_WriteData;
          end
        end
        ACCESS: begin
          if (memBus.mem_ack) begin
            r_state  <= IDLE;
            r_memReq <= 1'b0;
          end
        end
        default: begin
          r_state  <= IDLE;
          r_memReq <= 1'b0;
        end
      endcase
    end
  end

  // MEM/WB register. A stalled cycle inserts a bubble by clearing the
  // side-effecting bits only; data and destination just hold.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_wbData     <= '0;
      r_wbDest     <= '0;
      r_wbRegWrite <= 1'b0;
      r_wbHlt      <= 1'b0;
    end else if (w_stall) begin
      r_wbRegWrite <= 1'b0;
      r_wbHlt      <= 1'b0;
    end else begin
      r_wbData     <= w_wbSel;
      r_wbDest     <= M_Destination;
      r_wbRegWrite <= M_RegWrite;
      r_wbHlt      <= M_hlt;
    end
  end

  assign memBus.mem_req   = r_memReq;
  assign memBus.mem_we    = r_memWe;
  assign memBus.mem_addr  = r_memAddr;
  assign memBus.mem_wdata = r_memWdata;

  assign stall           = w_stall;
  assign W_WriteBackData = r_wbData;
  assign W_Destination   = r_wbDest;
  assign W_RegWrite      = r_wbRegWrite;
  assign W_hlt           = r_wbHlt;

endmodule

// File: tb/tb_mem_stage_ctrl.sv
// Directed testbench for mem_stage_ctrl. Inputs change 1 time unit after a
// rising edge and outputs are sampled on the falling edge; the bench plays
// the data memory, answering each request after a chosen number of cycles.
module tb_mem_stage_ctrl;

  logic        clk;
  logic        rst_n;
  logic [3:0]  M_Destination;
  logic [15:0] M_ALUout;
  logic [15:0] M_WriteData;
  logic [15:0] M_Nxt_Pc;
  logic        M_hlt;
  logic        M_MemtoReg;
  logic        M_MemRead;
  logic        M_MemWrite;
  logic        M_RegWrite;
  logic        M_Pcs;
  logic        stall;
  logic [15:0] W_WriteBackData;
  logic [3:0]  W_Destination;
  logic        W_RegWrite;
  logic        W_hlt;

  int vecCount  = 0;
  int missCount = 0;

  mem_stage_ctrl_if #(.DATA_W(16)) bus ();

  mem_stage_ctrl #(.DATA_W(16)) dut (
    .clk             (clk),
    .rst_n           (rst_n),
    .M_Destination   (M_Destination),
    .M_ALUout        (M_ALUout),
    .M_WriteData     (M_WriteData),
    .M_Nxt_Pc        (M_Nxt_Pc),
    .M_hlt           (M_hlt),
    .M_MemtoReg      (M_MemtoReg),
    .M_MemRead       (M_MemRead),
    .M_MemWrite      (M_MemWrite),
    .M_RegWrite      (M_RegWrite),
    .M_Pcs           (M_Pcs),
    .memBus          (bus.master),
    .stall           (stall),
    .W_WriteBackData (W_WriteBackData),
    .W_Destination   (W_Destination),
    .W_RegWrite      (W_RegWrite),
    .W_hlt           (W_hlt)
  );

  // 10-unit clock period
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Single comparison point: counts every vector and reports a miscompare
  task automatic checkOutput(input string tag, input logic [31:0] observed,
                             input logic [31:0] expected);
    vecCount++;
    if (observed !== expected) begin
      missCount++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", tag, observed, expected);
    end
  endtask

  // Drive one EX/MEM register worth of inputs
  task automatic applyStimulus(input logic [3:0] dest, input logic [15:0] aluOut,
                               input logic [15:0] wdata, input logic [15:0] nxtPc,
                               input logic hlt, input logic memToReg,
                               input logic memRead, input logic memWrite,
                               input logic regWrite, input logic pcs);
    M_Destination = dest;
    M_ALUout      = aluOut;
    M_WriteData   = wdata;
    M_Nxt_Pc      = nxtPc;
    M_hlt         = hlt;
    M_MemtoReg    = memToReg;
    M_MemRead     = memRead;
    M_MemWrite    = memWrite;
    M_RegWrite    = regWrite;
    M_Pcs         = pcs;
  endtask

  task automatic applyNop();
    applyStimulus(4'd0, 16'h0, 16'h0, 16'h0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
  endtask

  // Run the memory op already on the inputs. The memory acks in the cycle
  // that begins ackDelay edges after the edge on which mem_req rose. The
  // bus is checked on the ack cycle; the task returns 1 unit after the edge
  // that completes the access, with mem_ack already dropped.
  task automatic doMemOp(input int ackDelay, input logic [15:0] rdata,
                         input logic expWe, input logic [15:0] expAddr,
                         input logic checkWdata, input logic [15:0] expWdata,
                         output int stallCnt);
    int  reqEdges;
    bit  acked;
    stallCnt = 0;
    reqEdges = 0;
    acked    = 1'b0;
    for (int c = 0; c < 40 && !acked; c++) begin
      @(negedge clk);
      if (stall) begin
        stallCnt++;
        if (c > 0) checkOutput("bubbleRegWrite", {31'd0, W_RegWrite}, 32'd0);
      end
      if (bus.mem_ack) begin
        acked = 1'b1;
        checkOutput("ackCycleStall", {31'd0, stall}, 32'd0);
        checkOutput("memWe", {31'd0, bus.mem_we}, {31'd0, expWe});
        checkOutput("memAddr", {16'd0, bus.mem_addr}, {16'd0, expAddr});
        if (checkWdata) checkOutput("memWdata", {16'd0, bus.mem_wdata}, {16'd0, expWdata});
      end
      @(posedge clk);
      #1;
      if (acked) begin
        bus.mem_ack = 1'b0;
      end else if (bus.mem_req) begin
        reqEdges++;
        if (reqEdges == ackDelay + 1) begin
          bus.mem_ack   = 1'b1;
          bus.mem_rdata = rdata;
        end
      end
    end
    checkOutput("ackSeen", {31'd0, acked}, 32'd1);
    bus.mem_ack = 1'b0;
  endtask

  initial begin
    int stallCnt;
    rst_n         = 1'b0;
    bus.mem_ack   = 1'b0;
    bus.mem_rdata = 16'h0;
    applyNop();

    // Reset held for two edges, then released
    repeat (2) @(posedge clk);
    @(negedge clk);
    checkOutput("rstReq", {31'd0, bus.mem_req}, 32'd0);
    rst_n = 1'b1;
    #1;
    checkOutput("rstStall", {31'd0, stall}, 32'd0);
    checkOutput("rstReq2", {31'd0, bus.mem_req}, 32'd0);
    checkOutput("rstWe", {31'd0, bus.mem_we}, 32'd0);
    checkOutput("rstAddr", {16'd0, bus.mem_addr}, 32'd0);
    checkOutput("rstWdata", {16'd0, bus.mem_wdata}, 32'd0);
    checkOutput("rstWbData", {16'd0, W_WriteBackData}, 32'd0);
    checkOutput("rstWbDest", {28'd0, W_Destination}, 32'd0);
    checkOutput("rstWbRegWrite", {31'd0, W_RegWrite}, 32'd0);
    checkOutput("rstWbHlt", {31'd0, W_hlt}, 32'd0);

    // ALU op: one cycle through MEM, no stall
    @(posedge clk); #1;
    applyStimulus(4'd3, 16'h1234, 16'h0, 16'h0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
    @(negedge clk);
    checkOutput("aluStall", {31'd0, stall}, 32'd0);
    @(posedge clk); #1;
    applyNop();
    @(negedge clk);
    checkOutput("aluStall2", {31'd0, stall}, 32'd0);
    checkOutput("aluWbData", {16'd0, W_WriteBackData}, 32'h1234);
    checkOutput("aluWbDest", {28'd0, W_Destination}, 32'd3);
    checkOutput("aluWbRegWrite", {31'd0, W_RegWrite}, 32'd1);

    // Load from 0x0040, acked 3 cycles after the request: stall 4 cycles
    @(posedge clk); #1;
    applyStimulus(4'd5, 16'h0040, 16'h0, 16'h0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0);
    doMemOp(3, 16'hBEEF, 1'b0, 16'h0040, 1'b0, 16'h0, stallCnt);
    applyNop();
    checkOutput("loadStallCycles", stallCnt, 32'd4);
    @(negedge clk);
    checkOutput("loadWbData", {16'd0, W_WriteBackData}, 32'hBEEF);
    checkOutput("loadWbDest", {28'd0, W_Destination}, 32'd5);
    checkOutput("loadWbRegWrite", {31'd0, W_RegWrite}, 32'd1);
    checkOutput("loadReqDone", {31'd0, bus.mem_req}, 32'd0);

    // Store 0xA5A5 to 0x0010, acked 1 cycle after request: stall 2 cycles
    @(posedge clk); #1;
    applyStimulus(4'd7, 16'h0010, 16'hA5A5, 16'h0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
    doMemOp(1, 16'hFFFF, 1'b1, 16'h0010, 1'b1, 16'hA5A5, stallCnt);
    applyNop();
    checkOutput("storeStallCycles", stallCnt, 32'd2);
    @(negedge clk);
    checkOutput("storeWbRegWrite", {31'd0, W_RegWrite}, 32'd0);
    checkOutput("storeWbData", {16'd0, W_WriteBackData}, 32'h0010);

    // Pcs beats MemtoReg; a spurious ack while idle is ignored; halt passes
    @(posedge clk); #1;
    applyStimulus(4'd2, 16'h0F0F, 16'h0, 16'h0102, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1);
    bus.mem_ack   = 1'b1;
    bus.mem_rdata = 16'h5555;
    @(negedge clk);
    checkOutput("pcsStall", {31'd0, stall}, 32'd0);
    @(posedge clk); #1;
    bus.mem_ack = 1'b0;
    applyNop();
    @(negedge clk);
    checkOutput("pcsWbData", {16'd0, W_WriteBackData}, 32'h0102);
    checkOutput("pcsWbDest", {28'd0, W_Destination}, 32'd2);
    checkOutput("pcsWbRegWrite", {31'd0, W_RegWrite}, 32'd1);
    checkOutput("pcsWbHlt", {31'd0, W_hlt}, 32'd1);
    checkOutput("spuriousAckReq", {31'd0, bus.mem_req}, 32'd0);
    checkOutput("spuriousAckStall", {31'd0, stall}, 32'd0);

    // Reset asserted mid-access drops mem_req without waiting for a clock
    @(posedge clk); #1;
    applyStimulus(4'd4, 16'h0080, 16'h0, 16'h0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0);
    @(posedge clk); #1;
    @(negedge clk);
    checkOutput("midReqHigh", {31'd0, bus.mem_req}, 32'd1);
    checkOutput("midStall", {31'd0, stall}, 32'd1);
    #2;
    applyNop();
    rst_n = 1'b0;
    #1;
    checkOutput("midRstReq", {31'd0, bus.mem_req}, 32'd0);
    checkOutput("midRstStall", {31'd0, stall}, 32'd0);
    @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    checkOutput("postRstStall", {31'd0, stall}, 32'd0);

    // Next op after the abort: read+write together behaves as a write
    @(posedge clk); #1;
    applyStimulus(4'd6, 16'h0020, 16'h1111, 16'h0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0);
    doMemOp(2, 16'h2222, 1'b1, 16'h0020, 1'b1, 16'h1111, stallCnt);
    applyNop();
    checkOutput("rwStallCycles", stallCnt, 32'd3);
    @(negedge clk);
    checkOutput("rwReqDone", {31'd0, bus.mem_req}, 32'd0);
    checkOutput("rwWbRegWrite", {31'd0, W_RegWrite}, 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", vecCount, missCount);
    $finish;
  end

endmodule
